// File: rtl/fetch_sequencer.sv
// Fetch/decode/execute/writeback control sequencer sitting in front of the
// instruction decoder: owns pc and the instruction register, fetches over req/valid.
module fetch_sequencer #(
  parameter int                ADDR_W   = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                TIMEOUT  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [15:0]       imem_rdata,
  input  logic              imem_valid,
  output logic [15:0]       instr_out,
  output logic              instr_valid,
  input  logic              reg_write_enable,
  output logic              exec_en,
  output logic              wb_en,
  output logic [ADDR_W-1:0] pc,
  output logic              busy,
  output logic              halted,
  output logic              fault,
  output logic [2:0]        state_dbg
);

  // Handshake: a fetch completes on any rising edge where imem_req and
  // imem_valid are both high; imem_valid is ignored while imem_req is low.

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [2:0] OP_HALT = 3'b111;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_DECODE    = 3'd2,
    S_EXECUTE   = 3'd3,
    S_WRITEBACK = 3'd4,
    S_HALT      = 3'd5
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [15:0]       instr_q, instr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              fault_q, fault_d;
  logic              imem_req_q, imem_req_d;
  logic              instr_valid_q, instr_valid_d;
  logic              exec_en_q, exec_en_d;
  logic              wb_slot_q, wb_slot_d;
  logic              busy_q, busy_d;
  logic              halted_q, halted_d;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    cnt_d   = cnt_q;
    fault_d = fault_q;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (start) state_d = S_FETCH;
      end
      S_FETCH: begin
        if (imem_valid) begin
          instr_d = imem_rdata;
          cnt_d   = '0;
          state_d = S_DECODE;
        end else if (cnt_q == CNT_LAST) begin
          fault_d = 1'b1;
          cnt_d   = '0;
          state_d = S_HALT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DECODE: begin
        if (instr_q[15:13] == OP_HALT) state_d = S_HALT;
        else                           state_d = S_EXECUTE;
      end
      S_EXECUTE: state_d = S_WRITEBACK;
      S_WRITEBACK: begin
        pc_d    = pc_q + ADDR_W'(1);
        state_d = S_FETCH;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase

    // Outputs are decoded from the next state so they come straight from flops.
    imem_req_d    = (state_d == S_FETCH);
    instr_valid_d = (state_d == S_DECODE);
    exec_en_d     = (state_d == S_EXECUTE);
    wb_slot_d     = (state_d == S_WRITEBACK);
    halted_d      = (state_d == S_HALT);
    busy_d        = (state_d != S_IDLE) && (state_d != S_HALT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      pc_q          <= RESET_PC;
      instr_q       <= 16'h0000;
      cnt_q         <= '0;
      fault_q       <= 1'b0;
      imem_req_q    <= 1'b0;
      instr_valid_q <= 1'b0;
      exec_en_q     <= 1'b0;
      wb_slot_q     <= 1'b0;
      busy_q        <= 1'b0;
      halted_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      cnt_q         <= cnt_d;
      fault_q       <= fault_d;
      imem_req_q    <= imem_req_d;
      instr_valid_q <= instr_valid_d;
      exec_en_q     <= exec_en_d;
      wb_slot_q     <= wb_slot_d;
      busy_q        <= busy_d;
      halted_q      <= halted_d;
    end
  end

  assign imem_req    = imem_req_q;
  assign imem_addr   = pc_q;
  assign instr_out   = instr_q;
  assign instr_valid = instr_valid_q;
  assign exec_en     = exec_en_q;
  // The decoder's write-enable passes straight through during WRITEBACK only.
  assign wb_en       = wb_slot_q & reg_write_enable;
  assign pc          = pc_q;
  assign busy        = busy_q;
  assign halted      = halted_q;
  assign fault       = fault_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: memory responder, decoder stand-in, instruction-level
// reference model compared every cycle, plus directed scenarios with literal checks.
module tb_fetch_sequencer;
  localparam int ADDR_W  = 8;
  localparam int TIMEOUT = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic [15:0]       imem_rdata = 16'h0000;
  logic              imem_valid = 1'b0;
  logic [15:0]       instr_out;
  logic              instr_valid;
  logic              reg_write_enable;
  logic              exec_en;
  logic              wb_en;
  logic [ADDR_W-1:0] pc;
  logic              busy;
  logic              halted;
  logic              fault;
  logic [2:0]        state_dbg;

  fetch_sequencer #(.ADDR_W(ADDR_W), .RESET_PC(8'h00), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .start(start),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .imem_valid(imem_valid), .instr_out(instr_out), .instr_valid(instr_valid),
    .reg_write_enable(reg_write_enable), .exec_en(exec_en), .wb_en(wb_en),
    .pc(pc), .busy(busy), .halted(halted), .fault(fault), .state_dbg(state_dbg)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // Decoder stand-in: NOP opcode 110 never writes the register file.
  assign reg_write_enable = (instr_out[15:13] != 3'b110);

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- memory responder ----------------
  logic [15:0] mem [0:255];
  int mem_lat = 0;
  bit mem_dead = 0;
  bit stray_en = 0;
  int req_cycles = 0;

  always @(negedge clk) begin
    if (imem_req === 1'b1) begin
      imem_valid = !mem_dead && (req_cycles >= mem_lat);
      imem_rdata = imem_valid ? mem[imem_addr] : 16'($urandom);
      req_cycles++;
    end else begin
      req_cycles = 0;
      imem_valid = stray_en ? 1'($urandom_range(0, 1)) : 1'b0;
      imem_rdata = 16'($urandom);
    end
  end

  // ---------------- reference model ----------------
  // mode: 0 idle, 1 running, 2 halted. stage: position within the 4-step instruction.
  int          m_mode = 0;
  int          m_stage = 0;
  int          m_fetch_cycles = 0;
  logic [7:0]  m_pc = 8'h00;
  logic [15:0] m_ir = 16'h0000;
  bit          m_fault = 0;
  bit          chk_en = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_mode = 0; m_stage = 0; m_fetch_cycles = 0;
      m_pc = 8'h00; m_ir = 16'h0000; m_fault = 0; chk_en = 1;
    end else if (m_mode == 0) begin
      if (start) begin m_mode = 1; m_stage = 0; m_fetch_cycles = 0; end
    end else if (m_mode == 1) begin
      case (m_stage)
        0: begin
          m_fetch_cycles++;
          if (imem_valid) begin
            m_ir = mem[m_pc];
            m_stage = 1;
            m_fetch_cycles = 0;
          end else if (m_fetch_cycles >= TIMEOUT) begin
            m_fault = 1;
            m_mode = 2;
          end
        end
        1: if (m_ir[15:13] == 3'b111) m_mode = 2; else m_stage = 2;
        2: m_stage = 3;
        default: begin m_pc = m_pc + 8'd1; m_stage = 0; end
      endcase
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    #1;
    if (chk_en) begin
      check("m_imem_req",    imem_req,    (m_mode == 1 && m_stage == 0));
      check("m_imem_addr",   imem_addr,   m_pc);
      check("m_pc",          pc,          m_pc);
      check("m_instr_out",   instr_out,   m_ir);
      check("m_instr_valid", instr_valid, (m_mode == 1 && m_stage == 1));
      check("m_exec_en",     exec_en,     (m_mode == 1 && m_stage == 2));
      check("m_wb_en",       wb_en,       (m_mode == 1 && m_stage == 3 && m_ir[15:13] != 3'b110));
      check("m_busy",        busy,        (m_mode == 1));
      check("m_halted",      halted,      (m_mode == 2));
      check("m_fault",       fault,       m_fault);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    rst = 1'b1;
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic fill_mem(input logic [15:0] val);
    for (int i = 0; i < 256; i++) mem[i] = val;
  endtask

  // ---------------- directed scenarios ----------------
  logic [7:0] exp_q[$];
  int ex_cyc[$];
  int wb_cyc[$];

  initial begin
    int n;
    int wb_cnt;
    bit flag;
    bit seen_ff;

    fill_mem(16'hE000);

    // Reset and idle
    do_reset();
    #2;
    check("rst_pc", pc, 8'h00);
    check("rst_instr", instr_out, 16'h0000);
    check("rst_outputs", {imem_req, instr_valid, exec_en, wb_en, busy, halted, fault}, 7'b0);
    repeat (5) @(negedge clk);
    #2;
    check("idle_hold", {imem_req, busy, halted}, 3'b000);

    // Zero-wait program: ADD, LDI, HALT
    stray_en = 1;
    mem[0] = 16'h0A40; mem[1] = 16'hA0FF; mem[2] = 16'hE000;
    exp_q = {8'h00, 8'h01, 8'h02};
    ex_cyc = {};
    wb_cyc = {};
    start = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      start = 1'b0;
      #2;
      if (imem_req) begin
        if (exp_q.size() == 0) check("zw_extra_fetch", imem_addr, 8'hxx);
        else check("zw_fetch_addr", imem_addr, exp_q.pop_front());
      end
      if (exec_en) ex_cyc.push_back(k);
      if (wb_en) wb_cyc.push_back(k);
    end
    check("zw_fetch_count_left", exp_q.size(), 0);
    check("zw_exec_n", ex_cyc.size(), 2);
    check("zw_exec_0", ex_cyc.size() > 0 ? ex_cyc[0] : -1, 3);
    check("zw_exec_1", ex_cyc.size() > 1 ? ex_cyc[1] : -1, 7);
    check("zw_wb_n", wb_cyc.size(), 2);
    check("zw_wb_0", wb_cyc.size() > 0 ? wb_cyc[0] : -1, 4);
    check("zw_wb_1", wb_cyc.size() > 1 ? wb_cyc[1] : -1, 8);
    check("zw_halted", halted, 1'b1);
    check("zw_pc", pc, 8'h02);
    do_reset();

    // Wait states, start held high throughout
    mem_lat = 3;
    mem[0] = 16'h1234; mem[1] = 16'hE000;
    n = 0;
    flag = 0;
    start = 1'b1;
    for (int k = 0; k < 40 && !halted; k++) begin
      @(negedge clk);
      #2;
      if (imem_req && !flag) begin
        n++;
        check("ws_ir_hold", instr_out, 16'h0000);
      end
      if (instr_valid && !flag) begin
        flag = 1;
        check("ws_ir_capture", instr_out, 16'h1234);
      end
    end
    check("ws_req_len", n, 4);
    check("ws_halted", halted, 1'b1);
    check("ws_pc", pc, 8'h01);
    repeat (3) @(negedge clk);
    #2;
    check("ws_halt_ignores_start", {halted, busy}, 2'b10);
    start = 1'b0;
    do_reset();

    // Fetch timeout
    mem_lat = 0;
    mem_dead = 1;
    n = 0;
    start = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      start = (k % 3 == 0);
      #2;
      if (imem_req) n++;
    end
    start = 1'b0;
    check("to_fetch_cycles", n, TIMEOUT);
    check("to_fault", fault, 1'b1);
    check("to_halted", halted, 1'b1);
    check("to_req_low", imem_req, 1'b0);
    mem_dead = 0;
    do_reset();
    #2;
    check("to_fault_cleared", fault, 1'b0);

    // PC wrap through a memory full of NOPs
    fill_mem(16'hC000);
    wb_cnt = 0;
    flag = 0;
    seen_ff = 0;
    start = 1'b1;
    for (int k = 0; k < 1200 && !flag; k++) begin
      @(negedge clk);
      start = 1'b0;
      #2;
      if (wb_en) wb_cnt++;
      if (pc == 8'hFF) seen_ff = 1;
      if (seen_ff && imem_req && imem_addr == 8'h00) flag = 1;
    end
    check("wrap_seen", flag, 1'b1);
    check("wrap_pc", pc, 8'h00);
    check("wrap_no_wb", wb_cnt, 0);
    do_reset();

    // Reset while in EXECUTE
    fill_mem(16'hE000);
    mem[0] = 16'h0A40; mem[1] = 16'hA0FF;
    flag = 0;
    start = 1'b1;
    for (int k = 0; k < 20 && !flag; k++) begin
      @(negedge clk);
      start = 1'b0;
      #2;
      if (exec_en) flag = 1;
    end
    check("mr_exec_reached", flag, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #2;
    check("mr_exec_state", {busy, halted, exec_en, wb_en, imem_req}, 5'b0);
    check("mr_exec_pc", pc, 8'h00);
    check("mr_exec_ir", instr_out, 16'h0000);
    repeat (3) @(negedge clk);
    #2;
    check("mr_exec_stays_idle", {busy, wb_en, exec_en}, 3'b0);

    // Reset in FETCH with imem_valid high in the same cycle
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #2;
    check("mr_fetch_req", {imem_req, imem_valid}, 2'b11);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #2;
    check("mr_fetch_ir", instr_out, 16'h0000);
    check("mr_fetch_state", {busy, imem_req, instr_valid}, 3'b000);
    check("mr_fetch_pc", pc, 8'h00);

    repeat (2) @(negedge clk);
    #3;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
